// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style interrupt sequencer.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK1 = 2'd1,
    WAIT_ACK2 = 2'd2
  } state_t;

  localparam int unsigned IRQ_W        = 8;
  localparam int unsigned IDX_W        = 3;
  localparam logic [2:0]  SPURIOUS_IDX = 3'd7;

  // Rank 0 is the highest priority; the line just after lowest_pri ranks first.
  function automatic logic [2:0] rank(input logic [2:0] idx, input logic [2:0] lowest_pri);
    return idx - lowest_pri - 3'd1;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_picker.sv
// Combinational rotating-priority picker: returns the best-ranked set request bit.
module rotating_priority_picker
  import pic_pkg::*;
(
  input  logic [IRQ_W-1:0] req,
  input  logic [IDX_W-1:0] lowest_pri,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned r = 0; r < IRQ_W; r++) begin
      cand = lowest_pri + 3'd1 + r[IDX_W-1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt scheduler: IRR latching, masked fully-nested rotating arbitration,
// INT / two-pulse INTA handshake, vector generation and EOI retirement.
module interrupt_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned BASE_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IRQ-1:0]        irq_in,
  input  logic                      level_mode,
  input  logic [NUM_IRQ-1:0]        imr,
  input  logic [BASE_W-1:0]         vec_base,
  input  logic                      auto_eoi,
  input  logic                      init_done,
  input  logic                      inta_pulse,
  input  logic                      eoi_req,
  input  logic                      eoi_specific,
  input  logic [IDX_W-1:0]          eoi_level,
  input  logic                      rotate_on_eoi,
  output logic                      int_out,
  output logic [BASE_W+IDX_W-1:0]   vector_out,
  output logic                      vector_valid,
  output logic [NUM_IRQ-1:0]        irr,
  output logic [NUM_IRQ-1:0]        isr
);

  state_t                    state_q, state_d;
  logic [IRQ_W-1:0]          irr_q, irr_d, isr_q, isr_d, isr_e, irq_prev_q, qual;
  logic [IDX_W-1:0]          lp_q, lp_d, lp_e, sel_q, sel_d;
  logic                      int_q, int_d, spur_q, spur_d;
  logic [BASE_W+IDX_W-1:0]   vec_q, vec_d;
  logic                      isr_best_valid, cand_valid;
  logic [IDX_W-1:0]          isr_best_idx, cand_idx;
  logic [3:0]                min_rank;

  rotating_priority_picker u_isr_pick (
    .req        (isr_q),
    .lowest_pri (lp_q),
    .valid      (isr_best_valid),
    .idx        (isr_best_idx)
  );

  rotating_priority_picker u_irr_pick (
    .req        (qual),
    .lowest_pri (lp_e),
    .valid      (cand_valid),
    .idx        (cand_idx)
  );

  // EOI is resolved first so that a same-cycle acknowledge sees the retired isr/priority.
  always_comb begin
    isr_e = isr_q;
    lp_e  = lp_q;
    if (eoi_req) begin
      if (eoi_specific) begin
        if (isr_q[eoi_level]) begin
          isr_e[eoi_level] = 1'b0;
          if (rotate_on_eoi) lp_e = eoi_level;
        end
      end else if (isr_best_valid) begin
        isr_e[isr_best_idx] = 1'b0;
        if (rotate_on_eoi) lp_e = isr_best_idx;
      end
    end
  end

  always_comb begin
    min_rank = 4'd8;
    qual     = '0;
    for (int unsigned i = 0; i < IRQ_W; i++) begin
      if (isr_e[i] && ({1'b0, rank(i[IDX_W-1:0], lp_e)} < min_rank))
        min_rank = {1'b0, rank(i[IDX_W-1:0], lp_e)};
    end
    for (int unsigned i = 0; i < IRQ_W; i++) begin
      qual[i] = irr_q[i] & ~imr[i] & ({1'b0, rank(i[IDX_W-1:0], lp_e)} < min_rank);
    end
  end

  always_comb begin
    state_d      = state_q;
    int_d        = int_q;
    sel_d        = sel_q;
    spur_d       = spur_q;
    vec_d        = vec_q;
    vector_valid = 1'b0;
    isr_d        = isr_e;
    lp_d         = lp_e;
    if (level_mode) irr_d = irq_in & (~isr_q | irr_q);
    else            irr_d = irr_q | (irq_in & ~irq_prev_q);

    if (!init_done) begin
      state_d = IDLE;
      int_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand_valid) begin
            int_d   = 1'b1;
            state_d = WAIT_ACK1;
          end
        end
        WAIT_ACK1: begin
          if (inta_pulse) begin
            int_d   = 1'b0;
            state_d = WAIT_ACK2;
            if (cand_valid) begin
              sel_d           = cand_idx;
              spur_d          = 1'b0;
              isr_d[cand_idx] = 1'b1;
              irr_d[cand_idx] = 1'b0;
            end else begin
              sel_d  = SPURIOUS_IDX;
              spur_d = 1'b1;
            end
          end
        end
        WAIT_ACK2: begin
          if (inta_pulse) begin
            vector_valid = 1'b1;
            vec_d        = {vec_base, sel_q};
            state_d      = IDLE;
            if (auto_eoi && !spur_q) begin
              isr_d[sel_q] = 1'b0;
              if (rotate_on_eoi) lp_d = sel_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      irr_q      <= '0;
      isr_q      <= '0;
      irq_prev_q <= '0;
      lp_q       <= 3'd7;
      sel_q      <= '0;
      spur_q     <= 1'b0;
      int_q      <= 1'b0;
      vec_q      <= '0;
    end else begin
      state_q    <= state_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      irq_prev_q <= irq_in;
      lp_q       <= lp_d;
      sel_q      <= sel_d;
      spur_q     <= spur_d;
      int_q      <= int_d;
      vec_q      <= vec_d;
    end
  end

  assign int_out    = int_q;
  assign vector_out = vector_valid ? {vec_base, sel_q} : vec_q;
  assign irr        = irr_q;
  assign isr        = isr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer with hand-computed expectations.
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in, imr;
  logic       level_mode, auto_eoi, init_done, inta_pulse;
  logic       eoi_req, eoi_specific, rotate_on_eoi;
  logic [4:0] vec_base;
  logic [2:0] eoi_level;
  logic       int_out, vector_valid;
  logic [7:0] vector_out, irr, isr;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic       vv;
  logic [7:0] vo;

  interrupt_sequencer #(.NUM_IRQ(8), .BASE_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_in        (irq_in),
    .level_mode    (level_mode),
    .imr           (imr),
    .vec_base      (vec_base),
    .auto_eoi      (auto_eoi),
    .init_done     (init_done),
    .inta_pulse    (inta_pulse),
    .eoi_req       (eoi_req),
    .eoi_specific  (eoi_specific),
    .eoi_level     (eoi_level),
    .rotate_on_eoi (rotate_on_eoi),
    .int_out       (int_out),
    .vector_out    (vector_out),
    .vector_valid  (vector_valid),
    .irr           (irr),
    .isr           (isr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise inta_pulse for one cycle, capturing the combinational vector outputs.
  task automatic inta(output logic v, output logic [7:0] o);
    inta_pulse = 1'b1;
    #1;
    v = vector_valid;
    o = vector_out;
    @(negedge clk);
    inta_pulse = 1'b0;
  endtask

  task automatic nseoi();
    eoi_req = 1'b1; eoi_specific = 1'b0;
    @(negedge clk);
    eoi_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; imr = '0; level_mode = 1'b0; auto_eoi = 1'b0;
    init_done = 1'b0; inta_pulse = 1'b0; eoi_req = 1'b0; eoi_specific = 1'b0;
    rotate_on_eoi = 1'b0; vec_base = 5'b01000; eoi_level = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_int", {7'd0, int_out}, 8'h00);
    chk("rst_vec", vector_out, 8'h00);
    chk("rst_vv", {7'd0, vector_valid}, 8'h00);
    chk("rst_irr", irr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    reset = 1'b0; init_done = 1'b1;
    @(negedge clk);

    // Single IR3 edge request
    irq_in = 8'h08;
    @(negedge clk);
    chk("t1_irr", irr, 8'h08);
    chk("t1_int_lat", {7'd0, int_out}, 8'h00);
    @(negedge clk);
    chk("t1_int", {7'd0, int_out}, 8'h01);
    inta(vv, vo);
    chk("t1_vv_ack1", {7'd0, vv}, 8'h00);
    chk("t1_isr", isr, 8'h08);
    chk("t1_irr_clr", irr, 8'h00);
    chk("t1_int_drop", {7'd0, int_out}, 8'h00);
    @(negedge clk);
    inta(vv, vo);
    chk("t1_vv", {7'd0, vv}, 8'h01);
    chk("t1_vec", vo, 8'h43);
    chk("t1_vv_one", {7'd0, vector_valid}, 8'h00);
    chk("t1_vec_hold", vector_out, 8'h43);
    nseoi();
    chk("t1_eoi", isr, 8'h00);
    irq_in = '0;
    @(negedge clk);

    // IR5 and IR2 together: IR2 first, IR5 blocked until EOI
    irq_in = 8'h24;
    @(negedge clk);
    chk("t2_irr", irr, 8'h24);
    @(negedge clk);
    inta(vv, vo);
    chk("t2_isr", isr, 8'h04);
    chk("t2_irr_rem", irr, 8'h20);
    @(negedge clk);
    inta(vv, vo);
    chk("t2_vec2", vo, 8'h42);
    @(negedge clk); @(negedge clk);
    chk("t2_blocked", {7'd0, int_out}, 8'h00);
    nseoi();
    chk("t2_eoi_isr", isr, 8'h00);
    chk("t2_int5", {7'd0, int_out}, 8'h01);
    inta(vv, vo);
    @(negedge clk);
    inta(vv, vo);
    chk("t2_vec5", vo, 8'h45);
    chk("t2_isr5", isr, 8'h20);
    nseoi();
    irq_in = '0;
    @(negedge clk);

    // Masked IR4
    imr = 8'h10;
    irq_in = 8'h10;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("t3_masked", {7'd0, int_out}, 8'h00);
    imr = 8'h00;
    @(negedge clk);
    chk("t3_unmask", {7'd0, int_out}, 8'h01);
    inta(vv, vo);
    @(negedge clk);
    inta(vv, vo);
    chk("t3_vec", vo, 8'h44);
    nseoi();
    chk("t3_isr", isr, 8'h00);
    irq_in = '0;
    @(negedge clk);

    // Level mode spurious: IR6 falls before ACK1
    level_mode = 1'b1;
    @(negedge clk);
    irq_in = 8'h40;
    @(negedge clk);
    chk("t4_irr", irr, 8'h40);
    irq_in = 8'h00;
    @(negedge clk);
    chk("t4_int", {7'd0, int_out}, 8'h01);
    chk("t4_irr_fall", irr, 8'h00);
    inta(vv, vo);
    chk("t4_isr_ack1", isr, 8'h00);
    @(negedge clk);
    inta(vv, vo);
    chk("t4_vv", {7'd0, vv}, 8'h01);
    chk("t4_vec", vo, 8'h47);
    chk("t4_isr", isr, 8'h00);
    level_mode = 1'b0;
    @(negedge clk);

    // Auto-EOI with rotation
    auto_eoi = 1'b1; rotate_on_eoi = 1'b1;
    irq_in = 8'h02;
    @(negedge clk); @(negedge clk);
    inta(vv, vo);
    chk("t5_isr_ack1", isr, 8'h02);
    @(negedge clk);
    inta(vv, vo);
    chk("t5_vec1", vo, 8'h41);
    chk("t5_aeoi", isr, 8'h00);
    irq_in = '0;
    @(negedge clk);
    irq_in = 8'h05;
    @(negedge clk); @(negedge clk);
    chk("t5_int", {7'd0, int_out}, 8'h01);
    inta(vv, vo);
    chk("t5_isr_rot", isr, 8'h04);
    chk("t5_irr_rot", irr, 8'h01);
    @(negedge clk);
    inta(vv, vo);
    chk("t5_vec2", vo, 8'h42);
    chk("t5_aeoi2", isr, 8'h00);
    @(negedge clk);
    chk("t5_int0", {7'd0, int_out}, 8'h01);
    inta(vv, vo);
    @(negedge clk);
    inta(vv, vo);
    chk("t5_vec0", vo, 8'h40);
    auto_eoi = 1'b0; rotate_on_eoi = 1'b0; irq_in = '0;
    @(negedge clk);

    // Reset between ACK1 and ACK2
    irq_in = 8'h08;
    @(negedge clk); @(negedge clk);
    inta(vv, vo);
    chk("t6_isr_ack1", isr, 8'h08);
    reset = 1'b1; irq_in = '0;
    #1;
    chk("t6_rst_int", {7'd0, int_out}, 8'h00);
    chk("t6_rst_isr", isr, 8'h00);
    chk("t6_rst_irr", irr, 8'h00);
    chk("t6_rst_vec", vector_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    inta(vv, vo);
    chk("t6_no_vv", {7'd0, vv}, 8'h00);
    chk("t6_no_vec", vo, 8'h00);
    chk("t6_isr_after", isr, 8'h00);
    chk("t6_int_after", {7'd0, int_out}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
